// File: rtl/bus_interface_unit.sv
// Multiplexed external-bus master: a 16-bit address goes out in two byte phases, then one
// data phase that can stall on pin_rdy; it ends with either a response or a timeout error.
module bus_interface_unit #(
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  input  logic        pin_rdy,
  output logic [7:0]  uo_out,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    DATA    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_TIMEOUT - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [15:0] addr_q;
  logic        we_q;
  logic [7:0]  wdata_q;

  assign dbg_state = state;

  // Handshake: a request is taken on any rising edge where req_valid and req_ready are both 1.
  // Every output is a register loaded with the value belonging to the state being entered,
  // so the pins always describe the current state and nothing passes straight through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      addr_q    <= 16'h0000;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      uo_out    <= 8'h00;
      uio_out   <= 8'h00;
      uio_oe    <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            state     <= ADDR_HI;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            uo_out    <= req_addr[15:8];
            uio_out   <= {7'b0, ~req_we};
            uio_oe    <= 8'h01;
          end
        end
        ADDR_HI: begin
          state  <= ADDR_LO;
          uo_out <= addr_q[7:0];
        end
        ADDR_LO: begin
          state    <= DATA;
          wait_cnt <= 4'd0;
          if (we_q) begin
            uio_out <= wdata_q;
            uio_oe  <= 8'hFF;
          end else begin
            uio_out <= 8'h00;
            uio_oe  <= 8'h00;
          end
        end
        DATA: begin
          if (pin_rdy || wait_cnt == WAIT_LAST) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= ~pin_rdy;
            rsp_rdata <= (pin_rdy && !we_q) ? uio_in : 8'h00;
            uo_out    <= 8'h00;
            uio_out   <= 8'h00;
            uio_oe    <= 8'h00;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          uo_out    <= 8'h00;
          uio_out   <= 8'h00;
          uio_oe    <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Self-checking bench for bus_interface_unit: directed vector table, hand-written
// back-to-back and reset sequences, then random transactions against a response model.
module tb_bus_interface_unit;

  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_we;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        pin_rdy;
  logic [7:0]  uo_out;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  bus_interface_unit #(.WAIT_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .pin_rdy(pin_rdy), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    int          waits;
    logic [7:0]  din;
    logic        exp_err;
    logic [7:0]  exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response model: waits = number of stalled DATA cycles before pin_rdy rises.
  function automatic void model(input logic we, input int waits, input logic [7:0] din,
                                output logic err, output logic [7:0] rd, output int lat);
    err = (waits >= T);
    lat = err ? T + 3 : 4 + waits;
    rd  = (err || we) ? 8'h00 : din;
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic txn(input logic [15:0] a, input logic we, input logic [7:0] wd,
                     input int waits, input logic [7:0] din, input int exp_lat);
    int cyc;
    int k;
    logic [8:0] e;
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
    pin_rdy = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_valid = 1'b0; req_addr = 16'($urandom); req_we = 1'($urandom); req_wdata = 8'($urandom);
    chk("ahi_uo", uo_out, a[15:8]);
    chk("ahi_uio", uio_out, {7'b0, ~we});
    chk("ahi_oe", uio_oe, 8'h01);
    chk("ahi_busy", busy, 1);
    chk("ahi_ready", req_ready, 0);
    chk("ahi_rspv", rsp_valid, 0);
    pin_rdy = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("alo_uo", uo_out, a[7:0]);
    chk("alo_uio", uio_out, {7'b0, ~we});
    chk("alo_oe", uio_oe, 8'h01);
    pin_rdy = 1'($urandom_range(0, 1));
    @(negedge clk);
    cyc = 3;
    k = 0;
    while (rsp_valid !== 1'b1 && cyc < 24) begin
      chk("data_uo", uo_out, a[7:0]);
      chk("data_uio", uio_out, we ? wd : 8'h00);
      chk("data_oe", uio_oe, we ? 8'hFF : 8'h00);
      chk("data_busy", busy, 1);
      pin_rdy = (k >= waits);
      uio_in = pin_rdy ? din : 8'($urandom);
      k++;
      @(negedge clk);
      cyc++;
    end
    pin_rdy = 1'($urandom_range(0, 1));
    uio_in = 8'($urandom);
    chk("rsp_valid", rsp_valid, 1);
    chk("latency", cyc, exp_lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    chk("rsp_err", rsp_err, e[8]);
    chk("rsp_rdata", rsp_rdata, e[7:0]);
    chk("done_pins", {uo_out, uio_out, uio_oe}, 24'h0);
    chk("done_busy", busy, 1);
    @(negedge clk);
    chk("post_rspv", rsp_valid, 0);
    chk("post_ready", req_ready, 1);
    chk("post_busy", busy, 0);
    chk("hold_err", rsp_err, e[8]);
    chk("hold_rdata", rsp_rdata, e[7:0]);
  endtask

  initial begin
    vec_t vecs[6];
    logic [15:0] a5;
    logic [7:0]  cb;
    logic        m_err;
    logic [7:0]  m_rd;
    int          m_lat;
    int          waits;
    logic [15:0] ra;
    logic        rwe;
    logic [7:0]  rwd;
    logic [7:0]  rdin;

    vecs[0] = '{16'h12A5, 1'b0, 8'h00, 0,   8'h3C, 1'b0, 8'h3C, 4};
    vecs[1] = '{16'h0200, 1'b1, 8'h5A, 0,   8'h00, 1'b0, 8'h00, 4};
    vecs[2] = '{16'h4321, 1'b0, 8'h00, 2,   8'h77, 1'b0, 8'h77, 6};
    vecs[3] = '{16'hBEEF, 1'b0, 8'h00, 100, 8'h99, 1'b1, 8'h00, 7};
    vecs[4] = '{16'hFFFF, 1'b0, 8'h00, 3,   8'hAA, 1'b0, 8'hAA, 7};
    vecs[5] = '{16'h0001, 1'b1, 8'hC3, 100, 8'h00, 1'b1, 8'h00, 7};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = 16'h0; req_we = 1'b0; req_wdata = 8'h0;
    pin_rdy = 1'b1; uio_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_err", rsp_err, 0);
    chk("rst_pins", {uo_out, uio_out, uio_oe}, 24'h0);
    rst_n = 1'b1;

    // directed vector table
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
      txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].waits, vecs[i].din, vecs[i].exp_lat);
    end

    // back-to-back: req_valid held high, address changes every cycle
    a5 = 16'h0;
    for (int c = 0; c < 11; c++) begin
      cb = 8'(c * 37 + 1);
      req_valid = 1'b1;
      req_addr = {cb, ~cb};
      req_we = 1'b0;
      pin_rdy = 1'b1;
      if (c == 5) a5 = {cb, ~cb};
      chk("b2b_ready", req_ready, (c % 5 == 0) ? 1 : 0);
      if (c == 6) chk("b2b_addr_hi", uo_out, a5[15:8]);
      if (c == 7) chk("b2b_addr_lo", uo_out, a5[7:0]);
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 20 && busy === 1'b1; c++) @(negedge clk);
    chk("b2b_drain", busy, 0);

    // reset in the middle of a write data phase
    req_valid = 1'b1; req_addr = 16'h3344; req_we = 1'b1; req_wdata = 8'h5A; pin_rdy = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data_oe", uio_oe, 8'hFF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_oe", uio_oe, 8'h00);
    chk("abort_busy", busy, 0);
    chk("abort_rspv", rsp_valid, 0);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 8'h6B});
    txn(16'h5566, 1'b0, 8'h00, 1, 8'h6B, 5);

    // random transactions against the model
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rwe = 1'($urandom);
      rwd = 8'($urandom);
      rdin = 8'($urandom);
      waits = $urandom_range(0, T + 1);
      model(rwe, waits, rdin, m_err, m_rd, m_lat);
      exp_q.push_back({m_err, m_rd});
      txn(ra, rwe, rwd, waits, rdin, m_lat);
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_interface_unit.md
BUS_INTERFACE_UNIT -- requirements
Module: bus_interface_unit

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 15, meaning the maximum number of consecutive stalled data-phase cycles (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, core requests a bus cycle.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_addr, input, 16, target address.
REQ-007 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_wdata, input, 8, write data.
REQ-009 SHALL have port rsp_valid, output, 1, one-cycle completion strobe.
REQ-010 SHALL have port rsp_rdata, output, 8, read data.
REQ-011 SHALL have port rsp_err, output, 1, cycle ended by timeout.
REQ-012 SHALL have port busy, output, 1, unit not in IDLE.
REQ-013 SHALL have port pin_rdy, input, 1, external memory ready (1 = data valid or accepted).
REQ-014 SHALL have port uo_out, output, 8, multiplexed address pins.
REQ-015 SHALL have port uio_in, input, 8, bidirectional pins, input path.
REQ-016 SHALL have port uio_out, output, 8, bidirectional pins, output path.
REQ-017 SHALL have port uio_oe, output, 8, per-bit output enable (1 = drive).

Function
REQ-018 SHALL implement the FSM states IDLE, ADDR_HI, ADDR_LO, DATA and DONE.
REQ-019 SHALL drive req_ready=1 only in IDLE; a handshake occurs on a cycle with req_valid=1 and req_ready=1.
REQ-020 SHALL, on handshake, capture req_addr, req_we and req_wdata into internal registers and go to ADDR_HI; later changes on req_* SHALL be ignored until the next handshake.
REQ-021 SHALL, in IDLE: uo_out=8'h00, uio_out=8'h00, uio_oe=8'h00.
REQ-022 SHALL, in ADDR_HI: uo_out=addr[15:8], uio_out={7'b0, ~we}, uio_oe=8'h01; next state ADDR_LO.
REQ-023 SHALL, in ADDR_LO: uo_out=addr[7:0], uio_out={7'b0, ~we}, uio_oe=8'h01; next state DATA; wait counter cleared to 0.
REQ-024 SHALL, in DATA: uo_out=addr[7:0].
  - write: uio_out=wdata, uio_oe=8'hFF.
  - read: uio_out=8'h00, uio_oe=8'h00.
REQ-025 SHALL, in DATA with pin_rdy=1, go to DONE.
  - read: uio_in is registered into rsp_rdata and rsp_err=0.
  - write: rsp_rdata=8'h00 and rsp_err=0.
REQ-026 SHALL, in DATA with pin_rdy=0:
  - wait counter < WAIT_TIMEOUT-1: increment the counter and stay in DATA.
  - wait counter == WAIT_TIMEOUT-1: go to DONE with rsp_err=1 and rsp_rdata=8'h00.
REQ-027 SHALL, in DONE: assert rsp_valid=1 for exactly one cycle, drive pins as in IDLE, and go to IDLE.
REQ-028 SHALL hold rsp_rdata and rsp_err stable from DONE until the next DONE.
REQ-029 SHALL have a zero-wait latency of: handshake at cycle N, ADDR_HI N+1, ADDR_LO N+2, DATA N+3, rsp_valid at N+4, next handshake possible at N+5.
REQ-030 SHALL drive busy=1 in every state except IDLE.
REQ-031 SHALL sample pin_rdy only in DATA; pin_rdy in any other state has no effect.
REQ-032 SHALL generate all outputs from registered state only (no combinational path from req_* or pin_rdy to any output).

Reset
REQ-033 SHALL, when rst_n=0 at a rising clk edge, force: state IDLE, wait counter 0, captured registers 0, rsp_valid=0, rsp_rdata=8'h00, rsp_err=0, and all pins as in IDLE.
REQ-034 SHALL abort an in-flight cycle on reset with no rsp_valid, and SHALL accept a new request on the first cycle after rst_n returns to 1.

Verification
REQ-035 SHALL pass the zero-wait read test: read 0x12A5 with pin_rdy=1 and uio_in=0x3C.
  - uo_out is 0x12 then 0xA5; uio_out=0x01 and uio_oe=0x01 during the address phases.
  - rsp_valid at N+4 with rsp_rdata=0x3C and rsp_err=0.
REQ-036 SHALL pass the write test: write 0x0200 with data 0x5A and pin_rdy=1.
  - Address phases show uio_out=0x00.
  - DATA shows uio_out=0x5A and uio_oe=0xFF.
  - rsp_valid at N+4 with rsp_err=0 and rsp_rdata=0x00.
REQ-037 SHALL pass the wait-state test: read with pin_rdy=0 for 2 DATA cycles, then 1, uio_in=0x77.
  - rsp_valid at N+6 with rsp_rdata=0x77 and rsp_err=0.
REQ-038 SHALL pass the timeout test: WAIT_TIMEOUT=4 with pin_rdy held 0.
  - 4 DATA cycles (N+3..N+6), then rsp_valid at N+7 with rsp_err=1 and rsp_rdata=0x00.
  - req_ready=1 at N+8.
REQ-039 SHALL pass the back-to-back test: req_valid held 1 with changing req_addr.
  - Handshakes occur at N and N+5 only.
  - The second cycle uses the address present at N+5.
REQ-040 SHALL pass the reset test: rst_n=0 during DATA of a write.
  - Next cycle: uio_oe=0x00, busy=0, and no rsp_valid pulse.
